// File: rtl/multicore_pkg.sv
// Shared types and helpers for the multicore release sequencer and result merger.
package multicore_pkg;
  typedef enum logic [1:0] {HOLD, SEQ, RUN} state_t;

  localparam int VALID_CODE_DEF = 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multicore_sched_if.sv
// Core-facing buses plus the merged result channel of multicore_sched.
interface multicore_sched_if
  import multicore_pkg::*;
#(
  parameter int N_CORES = 24,
  parameter int DW      = 28,
  parameter int EW      = 4,
  parameter int CNT_W   = 16
);
  localparam int IW = idx_w(N_CORES);

  logic                    restart;
  logic [N_CORES*DW-1:0]   core_out;
  logic [N_CORES*EW-1:0]   core_en;
  logic [N_CORES-1:0]      core_rst;
  logic                    all_running;
  logic signed [DW-1:0]    io_out;
  logic [EW-1:0]           out_en;
  logic                    out_valid;
  logic [IW-1:0]           out_core;
  logic                    collision;
  logic [CNT_W-1:0]        drop_cnt;

  modport master (
    input  restart, core_out, core_en,
    output core_rst, all_running, io_out, out_en, out_valid, out_core,
           collision, drop_cnt
  );

  modport slave (
    output restart, core_out, core_en,
    input  core_rst, all_running, io_out, out_en, out_valid, out_core,
           collision, drop_cnt
  );
endinterface

// File: rtl/multicore_sched_arbiter.sv
// Combinational grant search over the eligible vector, starting at ptr and wrapping.
module ms_arbiter #(
  parameter int N  = 24,
  parameter int IW = 5,
  parameter int CW = 5
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] grant,
  output logic [CW-1:0] count
);
  int j;

  always_comb begin
    any   = 1'b0;
    grant = '0;
    count = '0;
    j     = 0;
    for (int i = 0; i < N; i++) count = count + CW'(elig[i]);
    for (int off = 0; off < N; off++) begin
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      if (!any && elig[j]) begin
        any   = 1'b1;
        grant = IW'(j);
      end
    end
  end
endmodule

// File: rtl/multicore_sched.sv
// Staggered per-core reset release plus a registered merge of the cores' result streams.
module multicore_sched
  import multicore_pkg::*;
#(
  parameter int N_CORES    = 24,
  parameter int DW         = 28,
  parameter int EW         = 4,
  parameter int VALID_CODE = VALID_CODE_DEF,
  parameter int STAGGER    = 18,
  parameter int RR_MODE    = 0,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  multicore_sched_if.master bus
);
  localparam int IW = idx_w(N_CORES);
  localparam int PW = $clog2(N_CORES + 1);
  localparam int SW = $clog2(STAGGER + 1);
  localparam int XW = CNT_W + 8;
  localparam logic [XW-1:0] DMAX = (XW'(1) << CNT_W) - XW'(1);

  state_t             state;
  logic [SW-1:0]      cnt;
  logic [IW-1:0]      idx, rr_ptr, grant;
  logic [PW-1:0]      n_elig;
  logic               any;
  logic [N_CORES-1:0] elig;
  logic [XW-1:0]      drop_sum;
  logic [CNT_W-1:0]   drop_next;

  // Cores still held in reset may drive garbage on their out_en slot.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_CORES; i++)
      elig[i] = (bus.core_en[i*EW +: EW] == EW'(VALID_CODE)) && !bus.core_rst[i];
  end

  ms_arbiter #(.N(N_CORES), .IW(IW), .CW(PW)) u_arb (
    .elig  (elig),
    .ptr   ((RR_MODE != 0) ? rr_ptr : IW'(0)),
    .any   (any),
    .grant (grant),
    .count (n_elig)
  );

  always_comb begin
    drop_sum  = XW'(bus.drop_cnt) + XW'(n_elig) - XW'(1);
    drop_next = (drop_sum > DMAX) ? DMAX[CNT_W-1:0] : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || bus.restart) begin
      state           <= HOLD;
      cnt             <= '0;
      idx             <= '0;
      bus.core_rst    <= '1;
      bus.all_running <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_en      <= '0;
      bus.collision   <= 1'b0;
      bus.drop_cnt    <= '0;
      if (rst) begin
        rr_ptr       <= '0;
        bus.io_out   <= '0;
        bus.out_core <= '0;
      end
    end else begin
      case (state)
        HOLD: state <= SEQ;
        SEQ: begin
          bus.core_rst[idx] <= 1'b0;
          if (idx == IW'(N_CORES - 1)) begin
            state           <= RUN;
            bus.all_running <= 1'b1;
          end else if (cnt == SW'(STAGGER - 1)) begin
            cnt <= '0;
            idx <= idx + IW'(1);
          end else begin
            cnt <= cnt + SW'(1);
          end
        end
        default: ;
      endcase

      bus.out_valid <= any;
      bus.out_en    <= any ? EW'(VALID_CODE) : '0;
      if (any) begin
        bus.io_out   <= bus.core_out[int'(grant)*DW +: DW];
        bus.out_core <= grant;
        rr_ptr       <= (grant == IW'(N_CORES - 1)) ? '0 : grant + IW'(1);
      end
      if (n_elig > PW'(1)) begin
        bus.collision <= 1'b1;
        bus.drop_cnt  <= drop_next;
      end
    end
  end
endmodule

// File: tb/tb_multicore_sched.sv
// Directed bench: three 4-core instances (fixed priority, round-robin, 2-bit drop counter).
module tb_multicore_sched;
  import multicore_pkg::*;

  localparam int N  = 4;
  localparam int DW = 12;
  localparam int EW = 4;
  localparam int S  = 3;

  typedef struct {
    int             core;
    logic [DW-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multicore_sched_if #(.N_CORES(N), .DW(DW), .EW(EW), .CNT_W(16)) if_a ();
  multicore_sched_if #(.N_CORES(N), .DW(DW), .EW(EW), .CNT_W(16)) if_b ();
  multicore_sched_if #(.N_CORES(N), .DW(DW), .EW(EW), .CNT_W(2))  if_c ();

  multicore_sched #(.N_CORES(N), .DW(DW), .EW(EW), .VALID_CODE(1), .STAGGER(S),
                    .RR_MODE(0), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  multicore_sched #(.N_CORES(N), .DW(DW), .EW(EW), .VALID_CODE(1), .STAGGER(S),
                    .RR_MODE(1), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  multicore_sched #(.N_CORES(N), .DW(DW), .EW(EW), .VALID_CODE(1), .STAGGER(S),
                    .RR_MODE(0), .CNT_W(2))  dut_c (.clk(clk), .rst(rst), .bus(if_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the next expected result and compares it against the output channel.
  task automatic check_out(input string tag, input logic v, input logic [1:0] core,
                           input logic [DW-1:0] io, input logic [EW-1:0] en);
    exp_t e;
    chk({tag, ".valid"}, 64'(v), 64'(1));
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".core"}, 64'(core), 64'(e.core));
      chk({tag, ".io"},   64'(io),   64'(e.data));
      chk({tag, ".en"},   64'(en),   64'(1));
    end
  endtask

  function automatic logic [N-1:0] exp_rst(input int k);
    logic [N-1:0] r;
    r = '1;
    for (int i = 0; i < N; i++) if (k >= 1 + S*i) r[i] = 1'b0;
    return r;
  endfunction

  function automatic logic [N*EW-1:0] en_vec(input logic [N-1:0] m);
    logic [N*EW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) if (m[i]) v[i*EW +: EW] = EW'(1);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] data_vec(input int base);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(base + 16*i);
    return v;
  endfunction

  function automatic logic [DW-1:0] slot(input logic [N*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  initial begin
    logic [N*DW-1:0] dv;
    if_a.restart = 0; if_a.core_out = '0; if_a.core_en = '0;
    if_b.restart = 0; if_b.core_out = '0; if_b.core_en = '0;
    if_c.restart = 0; if_c.core_out = '0; if_c.core_en = '0;

    // Reset state
    tick(); tick();
    chk("rst.core_rst",    64'(if_a.core_rst),    64'(4'hF));
    chk("rst.all_running", 64'(if_a.all_running), 64'(0));
    chk("rst.io_out",      64'($unsigned(if_a.io_out)), 64'(0));
    chk("rst.out_en",      64'(if_a.out_en),      64'(0));
    chk("rst.out_valid",   64'(if_a.out_valid),   64'(0));
    chk("rst.out_core",    64'(if_a.out_core),    64'(0));
    chk("rst.collision",   64'(if_a.collision),   64'(0));
    chk("rst.drop_cnt",    64'(if_a.drop_cnt),    64'(0));

    // Release sequence; core 3 claims a result while still in reset
    if_a.core_en = en_vec(4'b1000);
    if_a.core_out = data_vec(3);
    rst = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 6) if_a.core_en = '0;
      tick();
      chk($sformatf("seq%0d.core_rst_a", k), 64'(if_a.core_rst), 64'(exp_rst(k)));
      chk($sformatf("seq%0d.core_rst_b", k), 64'(if_b.core_rst), 64'(exp_rst(k)));
      chk($sformatf("seq%0d.run_a", k), 64'(if_a.all_running), 64'(k >= 10));
      chk($sformatf("seq%0d.masked", k), 64'(if_a.out_valid), 64'(0));
    end

    // Single result, fixed priority
    if_a.core_out = '0;
    if_a.core_out[2*DW +: DW] = -12'sd5;
    if_a.core_en = en_vec(4'b0100);
    sb.push_back('{core: 2, data: 12'hFFB});
    tick();
    if_a.core_en = '0;
    check_out("single", if_a.out_valid, if_a.out_core, if_a.io_out, if_a.out_en);
    tick();
    chk("single.idle_valid", 64'(if_a.out_valid), 64'(0));
    chk("single.idle_en",    64'(if_a.out_en),    64'(0));
    chk("single.hold_io",    64'($unsigned(if_a.io_out)), 64'(12'hFFB));
    chk("single.hold_core",  64'(if_a.out_core),  64'(2));

    // Collisions under fixed priority
    dv = data_vec(40);
    if_a.core_out = dv;
    if_a.core_en = en_vec(4'b1010);
    sb.push_back('{core: 1, data: slot(dv, 1)});
    tick();
    check_out("coll2", if_a.out_valid, if_a.out_core, if_a.io_out, if_a.out_en);
    chk("coll2.collision", 64'(if_a.collision), 64'(1));
    chk("coll2.drop_cnt",  64'(if_a.drop_cnt),  64'(1));
    if_a.core_en = en_vec(4'b1111);
    sb.push_back('{core: 0, data: slot(dv, 0)});
    tick();
    if_a.core_en = '0;
    check_out("coll4", if_a.out_valid, if_a.out_core, if_a.io_out, if_a.out_en);
    chk("coll4.drop_cnt",  64'(if_a.drop_cnt),  64'(4));

    // Round-robin between cores 0 and 1
    dv = data_vec(7);
    if_b.core_out = dv;
    if_b.core_en = en_vec(4'b0011);
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{core: k % 2, data: slot(dv, k % 2)});
      tick();
      check_out($sformatf("rr%0d", k), if_b.out_valid, if_b.out_core, if_b.io_out, if_b.out_en);
    end
    if_b.core_en = '0;
    chk("rr.drop_cnt",  64'(if_b.drop_cnt),  64'(4));
    chk("rr.collision", 64'(if_b.collision), 64'(1));

    // Restart held for two cycles, then the sequence replays
    if_a.restart = 1;
    tick(); tick();
    if_a.restart = 0;
    chk("restart.core_rst",  64'(if_a.core_rst),    64'(4'hF));
    chk("restart.collision", 64'(if_a.collision),   64'(0));
    chk("restart.drop_cnt",  64'(if_a.drop_cnt),    64'(0));
    chk("restart.valid",     64'(if_a.out_valid),   64'(0));
    chk("restart.running",   64'(if_a.all_running), 64'(0));
    for (int k = 0; k < 11; k++) begin
      tick();
      chk($sformatf("reseq%0d.core_rst", k), 64'(if_a.core_rst), 64'(exp_rst(k)));
      chk($sformatf("reseq%0d.run", k), 64'(if_a.all_running), 64'(k >= 10));
    end

    // Saturating drop counter
    dv = data_vec(100);
    if_c.core_out = dv;
    if_c.core_en = en_vec(4'b1111);
    sb.push_back('{core: 0, data: slot(dv, 0)});
    tick();
    check_out("sat3", if_c.out_valid, if_c.out_core, if_c.io_out, if_c.out_en);
    chk("sat3.drop_cnt", 64'(if_c.drop_cnt), 64'(3));
    if_c.core_en = en_vec(4'b0011);
    sb.push_back('{core: 0, data: slot(dv, 0)});
    tick();
    if_c.core_en = '0;
    check_out("sat5", if_c.out_valid, if_c.out_core, if_c.io_out, if_c.out_en);
    chk("sat5.drop_cnt", 64'(if_c.drop_cnt), 64'(3));

    // Restart into SEQ, produce a result, then rst mid-sequence
    if_c.restart = 1;
    tick();
    if_c.restart = 0;
    chk("c_restart.drop_cnt", 64'(if_c.drop_cnt), 64'(0));
    tick(); tick();
    chk("c_seq.core_rst", 64'(if_c.core_rst), 64'(4'hE));
    if_c.core_en = en_vec(4'b0001);
    sb.push_back('{core: 0, data: slot(dv, 0)});
    tick();
    check_out("c_seq", if_c.out_valid, if_c.out_core, if_c.io_out, if_c.out_en);
    rst = 1;
    tick();
    chk("midrst.core_rst",  64'(if_c.core_rst),    64'(4'hF));
    chk("midrst.running",   64'(if_c.all_running), 64'(0));
    chk("midrst.io_out",    64'($unsigned(if_c.io_out)), 64'(0));
    chk("midrst.out_en",    64'(if_c.out_en),      64'(0));
    chk("midrst.valid",     64'(if_c.out_valid),   64'(0));
    chk("midrst.out_core",  64'(if_c.out_core),    64'(0));
    chk("midrst.collision", 64'(if_c.collision),   64'(0));
    chk("midrst.drop_cnt",  64'(if_c.drop_cnt),    64'(0));
    chk("sb.empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
